// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 encodings, fault codes,
// FSM states and the store lane helpers.
package mem_stage_pkg;

    localparam int TIMEOUT_CYC_DEFAULT = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic load_f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // size is funct3[1:0]: 00 byte, 01 half, 10 word
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
        input  dmem_rdata_i, dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
        output dmem_rdata_i, dmem_ack_i
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: picks the byte/half/word lane out of the
// returned memory word and sign- or zero-extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic        [31:0] shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'h0, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'h0, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one load/store to data memory, stalls the front of
// the pipe until the ack (or a timeout), and formats load data for MEM/WB.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [1:0]         MEM_ctrl_i,
    input  logic [2:0]         funct3_i,
    input  logic [31:0]        alu_result_i,
    input  logic [31:0]        rs2_data_i,
    mem_stage_if.master        dmem,
    output logic [31:0]        DM_o,
    output logic               stall_o,
    output logic [1:0]         fault_o
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       dm_q;
    logic [1:0]        fault_q;

    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic              is_rd, is_wr, f3_ok, misal, start, in_idle;
    logic [1:0]        off, issue_fault;
    logic [31:0]       load_data;

    assign off     = alu_result_i[1:0];
    assign is_rd   = (MEM_ctrl_i == 2'b10);
    assign is_wr   = (MEM_ctrl_i == 2'b01);
    assign f3_ok   = is_rd ? load_f3_legal(funct3_i) : store_f3_legal(funct3_i);
    assign misal   = is_misaligned(funct3_i[1:0], off);
    assign in_idle = (state_q == S_IDLE);
    assign start   = in_idle && valid_i && (is_rd || is_wr) && f3_ok && !misal;

    // Illegal encodings take priority: alignment is meaningless for a bad funct3.
    always_comb begin
        issue_fault = FAULT_NONE;
        if (valid_i && MEM_ctrl_i != 2'b00) begin
            if (MEM_ctrl_i == 2'b11 || !f3_ok) issue_fault = FAULT_ILLEGAL;
            else if (misal)                    issue_fault = FAULT_MISALIGN;
        end
    end

    // Request fields are captured at issue so they stay stable through WAIT.
    always_ff @(posedge clk_i) begin
        if (start) begin
            we_q    <= is_wr;
            addr_q  <= {alu_result_i[31:2], 2'b00};
            wdata_q <= store_wdata(funct3_i[1:0], rs2_data_i);
            wstrb_q <= store_strobe(funct3_i[1:0], off);
            f3_q    <= funct3_i;
            off_q   <= off;
        end
    end

    load_align u_load_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .rdata_i  (dmem.dmem_rdata_i),
        .data_o   (load_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dm_q    <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (start) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (dmem.dmem_ack_i) begin
                        state_q <= S_DONE;
                        fault_q <= FAULT_NONE;
                        if (!we_q) dm_q <= load_data;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= S_DONE;
                        fault_q <= FAULT_TIMEOUT;
                        dm_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    fault_q <= FAULT_NONE;
                    cnt_q   <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req_o   = start || (state_q == S_WAIT);
    assign dmem.dmem_we_o    = in_idle ? is_wr : we_q;
    assign dmem.dmem_addr_o  = in_idle ? {alu_result_i[31:2], 2'b00} : addr_q;
    assign dmem.dmem_wdata_o = in_idle ? store_wdata(funct3_i[1:0], rs2_data_i) : wdata_q;
    assign dmem.dmem_wstrb_o = in_idle ? store_strobe(funct3_i[1:0], off) : wstrb_q;

    assign stall_o = start || (state_q == S_WAIT);
    assign fault_o = in_idle ? issue_fault :
                     (state_q == S_DONE) ? fault_q : FAULT_NONE;
    assign DM_o    = dm_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, faults, timeout and reset-in-WAIT.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [1:0]  ctrl;
    logic [2:0]  f3;
    logic [31:0] alu, rs2;
    logic [31:0] dm;
    logic        stall;
    logic [1:0]  fault;

    int n_chk  = 0;
    int n_fail = 0;

    int          s_stalls, s_unstable;
    logic        s_done, s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT_CYC(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .valid_i      (valid),
        .MEM_ctrl_i   (ctrl),
        .funct3_i     (f3),
        .alu_result_i (alu),
        .rs2_data_i   (rs2),
        .dmem         (bus),
        .DM_o         (dm),
        .stall_o      (stall),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go_idle();
        valid = 1'b0;
        ctrl  = 2'b00;
        bus.dmem_ack_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // Called #1 after a rising edge; returns at the falling edge of the first
    // non-stalled cycle (DONE, or the issue cycle if nothing was started).
    task automatic do_access(input logic [1:0] c, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] rd, input logic [31:0] ack_mask);
        valid = 1'b1; ctrl = c; f3 = f; alu = a; rs2 = d;
        bus.dmem_rdata_i = rd;
        s_stalls = 0; s_unstable = 0; s_done = 1'b0;
        for (int cy = 0; cy < 32; cy++) begin
            bus.dmem_ack_i = ack_mask[cy[4:0]];
            @(negedge clk);
            if (cy == 0) begin
                s_req = bus.dmem_req_o; s_we = bus.dmem_we_o; s_addr = bus.dmem_addr_o;
                s_wdata = bus.dmem_wdata_o; s_wstrb = bus.dmem_wstrb_o;
            end else if (stall) begin
                if ({bus.dmem_req_o, bus.dmem_we_o, bus.dmem_addr_o, bus.dmem_wdata_o, bus.dmem_wstrb_o}
                    !== {s_req, s_we, s_addr, s_wdata, s_wstrb})
                    s_unstable++;
            end
            if (!stall) begin
                s_done = 1'b1;
                break;
            end
            s_stalls++;
            @(posedge clk); #1;
        end
        bus.dmem_ack_i = 1'b0;
        chk("access_completes", 32'(s_done), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; ctrl = 2'b00; f3 = 3'b000; alu = '0; rs2 = '0;
        bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;

        // Reset state
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req",   32'(bus.dmem_req_o), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_dm",    dm, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // lw 0x100, ack in third WAIT cycle
        do_access(2'b10, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 32'h8);
        chk("lw_stalls",   32'(s_stalls), 32'd4);
        chk("lw_req0",     32'(s_req), 32'd1);
        chk("lw_we0",      32'(s_we), 32'd0);
        chk("lw_addr0",    s_addr, 32'h100);
        chk("lw_stable",   32'(s_unstable), 32'd0);
        chk("lw_dm",       dm, 32'hDEADBEEF);
        chk("lw_fault",    32'(fault), 32'd0);
        chk("lw_done_req", 32'(bus.dmem_req_o), 32'd0);
        go_idle();

        // Byte and half loads, minimum latency
        do_access(2'b10, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 32'h2);
        chk("lb_stalls", 32'(s_stalls), 32'd2);
        chk("lb_addr0",  s_addr, 32'h100);
        chk("lb_dm",     dm, 32'hFFFFFF80);
        go_idle();
        do_access(2'b10, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 32'h2);
        chk("lbu_dm", dm, 32'h00000080);
        go_idle();
        do_access(2'b10, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 32'h2);
        chk("lh_hi_dm", dm, 32'hFFFF80FF);
        go_idle();
        do_access(2'b10, 3'b001, 32'h100, 32'h0, 32'h12348001, 32'h2);
        chk("lh_lo_dm", dm, 32'hFFFF8001);
        go_idle();
        do_access(2'b10, 3'b101, 32'h100, 32'h0, 32'h12348001, 32'h2);
        chk("lhu_dm", dm, 32'h00008001);
        go_idle();

        // Stores: DM_o must hold the last load value
        do_access(2'b01, 3'b001, 32'h202, 32'h1234ABCD, 32'h55555555, 32'h2);
        chk("sh_addr",   s_addr, 32'h200);
        chk("sh_wstrb",  32'(s_wstrb), 32'hC);
        chk("sh_wdata",  s_wdata, 32'hABCDABCD);
        chk("sh_we",     32'(s_we), 32'd1);
        chk("sh_stalls", 32'(s_stalls), 32'd2);
        chk("sh_stable", 32'(s_unstable), 32'd0);
        chk("sh_dm_hold", dm, 32'h00008001);
        go_idle();
        do_access(2'b01, 3'b000, 32'h201, 32'h000000CD, 32'h0, 32'h2);
        chk("sb_wstrb", 32'(s_wstrb), 32'h2);
        chk("sb_wdata", s_wdata, 32'hCDCDCDCD);
        go_idle();
        do_access(2'b01, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 32'h2);
        chk("sw_wstrb", 32'(s_wstrb), 32'hF);
        chk("sw_wdata", s_wdata, 32'hCAFEF00D);
        chk("sw_addr",  s_addr, 32'h204);
        go_idle();

        // Faults at issue: no request, no stall
        do_access(2'b10, 3'b010, 32'h101, 32'h0, 32'h0, 32'h2);
        chk("lw_mis_stalls", 32'(s_stalls), 32'd0);
        chk("lw_mis_req",    32'(bus.dmem_req_o), 32'd0);
        chk("lw_mis_fault",  32'(fault), 32'd1);
        go_idle();
        do_access(2'b10, 3'b001, 32'h103, 32'h0, 32'h0, 32'h2);
        chk("lh_mis_fault", 32'(fault), 32'd1);
        go_idle();
        do_access(2'b10, 3'b011, 32'h100, 32'h0, 32'h0, 32'h2);
        chk("ld_ill_fault", 32'(fault), 32'd2);
        chk("ld_ill_req",   32'(bus.dmem_req_o), 32'd0);
        chk("ld_ill_stall", 32'(stall), 32'd0);
        go_idle();
        do_access(2'b01, 3'b100, 32'h100, 32'h0, 32'h0, 32'h2);
        chk("st_ill_fault", 32'(fault), 32'd2);
        go_idle();
        do_access(2'b11, 3'b010, 32'h100, 32'h0, 32'h0, 32'h2);
        chk("ctrl11_fault", 32'(fault), 32'd2);
        chk("ctrl11_req",   32'(bus.dmem_req_o), 32'd0);
        go_idle();
        do_access(2'b00, 3'b010, 32'h100, 32'h0, 32'h0, 32'h2);
        chk("ctrl00_fault", 32'(fault), 32'd0);
        chk("ctrl00_req",   32'(bus.dmem_req_o), 32'd0);
        go_idle();
        ctrl = 2'b10; f3 = 3'b010; alu = 32'h100;
        @(negedge clk);
        chk("novalid_req",   32'(bus.dmem_req_o), 32'd0);
        chk("novalid_fault", 32'(fault), 32'd0);
        go_idle();

        // Ack in the issue cycle is ignored
        do_access(2'b10, 3'b010, 32'h300, 32'h0, 32'h11223344, 32'h5);
        chk("early_ack_stalls", 32'(s_stalls), 32'd3);
        chk("early_ack_dm",     dm, 32'h11223344);
        go_idle();

        // Timeout after 8 WAIT cycles
        do_access(2'b10, 3'b010, 32'h400, 32'h0, 32'hFFFFFFFF, 32'h0);
        chk("to_stalls", 32'(s_stalls), 32'd9);
        chk("to_stable", 32'(s_unstable), 32'd0);
        chk("to_fault",  32'(fault), 32'd3);
        chk("to_dm",     dm, 32'h0);
        chk("to_req",    32'(bus.dmem_req_o), 32'd0);
        go_idle();
        @(negedge clk);
        chk("to_fault_clear", 32'(fault), 32'd0);
        @(posedge clk); #1;

        // Reset during WAIT, late ack ignored
        do_access(2'b10, 3'b010, 32'h500, 32'h0, 32'h55AA55AA, 32'h2);
        chk("pre_rst_dm", dm, 32'h55AA55AA);
        go_idle();
        valid = 1'b1; ctrl = 2'b10; f3 = 3'b010; alu = 32'h600;
        bus.dmem_rdata_i = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(negedge clk);
        chk("wait_stall", 32'(stall), 32'd1);
        rst_n = 1'b0; valid = 1'b0;
        #1;
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_req",   32'(bus.dmem_req_o), 32'd0);
        chk("rstw_dm",    dm, 32'h0);
        @(posedge clk); #1;
        bus.dmem_ack_i = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("late_ack_dm",    dm, 32'h0);
        chk("late_ack_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus.dmem_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_dm2",  dm, 32'h0);
        chk("late_ack_req",  32'(bus.dmem_req_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum cycles to wait for dmem_ack_i before faulting.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port valid_i, input, 1, EX/MEM slot holds a live instruction.
REQ-005 SHALL have port MEM_ctrl_i, input, 2, where bit1 = mem_read and bit0 = mem_write.
REQ-006 SHALL have port funct3_i, input, 3, access size and sign.
REQ-007 SHALL have port alu_result_i, input, 32, the byte address.
REQ-008 SHALL have port rs2_data_i, input, 32, the store data.
REQ-009 SHALL have the data-memory ports dmem_req_o (output, 1), dmem_we_o (output, 1), dmem_addr_o (output, 32, word-aligned), dmem_wdata_o (output, 32), dmem_wstrb_o (output, 4), dmem_rdata_i (input, 32) and dmem_ack_i (input, 1).
REQ-010 SHALL have port DM_o, output, 32, the formatted load data presented to the MEM/WB register.
REQ-011 SHALL have port stall_o, output, 1, which freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-012 SHALL have port fault_o, output, 2, where 00 = none, 01 = misaligned, 10 = illegal funct3, 11 = bus timeout.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-014 In IDLE, when valid_i=1, exactly one MEM_ctrl_i bit is set, the access is aligned and funct3 is legal, the block SHALL assert dmem_req_o combinationally and go to WAIT.
REQ-015 In WAIT, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o and dmem_wstrb_o SHALL stay stable until the cycle dmem_ack_i=1 is sampled.
REQ-016 On ack, the FSM SHALL go to DONE; a read SHALL register the formatted dmem_rdata_i into DM_o on that edge.
REQ-017 DONE SHALL last exactly one cycle, deassert stall_o, never issue a request, and return to IDLE.
REQ-018 stall_o SHALL equal (IDLE and a request is starting) or (state is WAIT); minimum latency is 2 cycles (issue cycle, ack in the next cycle, then DONE).
REQ-019 A zero-wait ack in the issue cycle SHALL be ignored; ack is sampled only in WAIT.
REQ-020 Loads SHALL be formatted as follows: funct3 000 = lb and 100 = lbu select the byte at addr[1:0]; 001 = lh and 101 = lhu select the half at addr[1]; 010 = lw is the full word; lb/lh are sign-extended and lbu/lhu zero-extended.
REQ-021 Stores SHALL use strobes sb = 0001<<addr[1:0], sh = 0011<<addr[1:0], sw = 1111, with dmem_wdata_o carrying the byte or half replicated across all lanes.
REQ-022 dmem_addr_o SHALL equal {alu_result_i[31:2], 2'b00}.
REQ-023 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL issue no request and no stall, with fault_o=01 for that cycle.
REQ-024 Illegal funct3 (loads 011/110/111; stores other than 000/001/010) SHALL issue no request, with fault_o=10.
REQ-025 A cycle counter SHALL run in WAIT; reaching TIMEOUT_CYC without ack SHALL go to DONE with fault_o=11 in DONE and DM_o=0, dropping dmem_req_o.
REQ-026 MEM_ctrl_i=11 SHALL be treated as illegal (fault_o=10); MEM_ctrl_i=00 or valid_i=0 SHALL produce fault_o=00 and no activity.
REQ-027 DM_o SHALL hold its value except on read capture or timeout.

Reset
REQ-028 rst_i=0 SHALL asynchronously force state=IDLE, counter=0 and DM_o=0; with the state at IDLE, stall_o=0, dmem_req_o=0 and fault_o=00.
REQ-029 Reset during WAIT SHALL abandon the access immediately; a late ack SHALL then be ignored.

Structure
REQ-030 A shared package SHALL hold the funct3 load/store constants, the fault codes, the state enum and the default TIMEOUT_CYC.
REQ-031 Load extraction/extension SHALL be in a combinational sub-module load_align.

Verification
REQ-032 lw, addr 0x100, ack after 3 WAIT cycles, rdata 0xDEADBEEF -> stall high 4 cycles, DM_o=0xDEADBEEF, wstrb irrelevant, fault 00.
REQ-033 lb/lbu, addr 0x103, rdata 0x80FF_0000 -> DM_o=0xFFFFFF80 / 0x00000080.
REQ-034 sh, addr 0x202, rs2 0x1234ABCD -> addr 0x200, wstrb 1100, wdata 0xABCDABCD, dmem_we_o=1.
REQ-035 lw, addr 0x101 -> no req, stall 0, fault_o=01; funct3 011 load -> fault_o=10.
REQ-036 lw, no ack with TIMEOUT_CYC=8 -> req dropped after 8 WAIT cycles, fault_o=11 in DONE, DM_o=0.
REQ-037 rst_i low mid-WAIT, ack one cycle later -> IDLE, DM_o=0, no capture.
